// File: rtl/touch_adc_reader.sv
// touch_adc_reader: serial front end for an ADS7843-style touch ADC.
// Waits for pen-down, then reads one 12-bit X and one 12-bit Y conversion
// over a 24-clock SPI-like frame each. Both coordinates are published together
// with a one-cycle NEW_COORD strobe. While the pen stays down, the cycle
// repeats after a holdoff.
//
// Ports:
//   CLK          system clock (single domain)
//   RST          synchronous, active-high reset
//   ADC_PENIRQ_N pen-down from ADC, active low, asynchronous
//   ADC_DOUT     serial data from ADC, asynchronous
//   ADC_CS_N     chip select, active low
//   ADC_DCLK     serial clock, CLK/(2*CLK_DIV)
//   ADC_DIN      serial command to ADC
//   X_COORD      last X result (12 bits)
//   Y_COORD      last Y result (12 bits)
//   NEW_COORD    one-cycle strobe; X_COORD/Y_COORD updated this cycle
module touch_adc_reader #(
   parameter int unsigned CLK_DIV     = 25,
   parameter int unsigned HOLDOFF_CYC = 500000,
   parameter logic [7:0]  CMD_X       = 8'h92,
   parameter logic [7:0]  CMD_Y       = 8'hD2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ADC_PENIRQ_N,
   input  logic        ADC_DOUT,
   output logic        ADC_CS_N,
   output logic        ADC_DCLK,
   output logic        ADC_DIN,
   output logic [11:0] X_COORD,
   output logic [11:0] Y_COORD,
   output logic        NEW_COORD
);

   localparam int unsigned DIV_W   = $clog2(CLK_DIV);
   localparam int unsigned TMR_MAX = (2 * CLK_DIV > HOLDOFF_CYC) ? 2 * CLK_DIV : HOLDOFF_CYC;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(2 * CLK_DIV - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYC - 1);
   localparam logic [5:0]       HALF_LAST = 6'd47;

   typedef enum logic [2:0] {IDLE, XFER_X, GAP, XFER_Y, DONE, HOLDOFF} state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt, div_nxt;
   logic [5:0]        half_cnt, half_nxt, half_inc;
   logic [TMR_W-1:0]  tmr, tmr_nxt;
   logic              cs_n, cs_n_nxt;
   logic              dclk, dclk_nxt;
   logic              din, din_nxt;
   logic [11:0]       x_cap, x_cap_nxt;
   logic [11:0]       x_coord, x_nxt;
   logic [11:0]       y_coord, y_nxt;
   logic              new_coord, new_nxt;
   logic              samp_nxt;
   logic [7:0]        cmd;

   logic              pen_meta, pen_s;
   logic              dout_meta, dout_s;
   logic [1:0]        samp_pipe;
   logic [11:0]       shreg;

   // Input synchronizers
   always_ff @(posedge CLK) begin
      if (RST) begin
         pen_meta  <= 1'b1;
         pen_s     <= 1'b1;
         dout_meta <= 1'b0;
         dout_s    <= 1'b0;
      end else begin
         pen_meta  <= ADC_PENIRQ_N;
         pen_s     <= pen_meta;
         dout_meta <= ADC_DOUT;
         dout_s    <= dout_meta;
      end
   end

   // The pin is caught by the first synchronizer flop on the edge where DCLK
   // rises; the sample strobe is delayed by the synchronizer depth so the
   // shift register takes exactly that value two cycles later.
   always_ff @(posedge CLK) begin
      if (RST) begin
         samp_pipe <= '0;
         shreg     <= '0;
      end else begin
         samp_pipe <= {samp_pipe[0], samp_nxt};
         if (samp_pipe[1]) shreg <= {shreg[10:0], dout_s};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         div_cnt   <= '0;
         half_cnt  <= '0;
         tmr       <= '0;
         cs_n      <= 1'b1;
         dclk      <= 1'b0;
         din       <= 1'b0;
         x_cap     <= '0;
         x_coord   <= '0;
         y_coord   <= '0;
         new_coord <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_nxt;
         half_cnt  <= half_nxt;
         tmr       <= tmr_nxt;
         cs_n      <= cs_n_nxt;
         dclk      <= dclk_nxt;
         din       <= din_nxt;
         x_cap     <= x_cap_nxt;
         x_coord   <= x_nxt;
         y_coord   <= y_nxt;
         new_coord <= new_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      half_nxt  = half_cnt;
      tmr_nxt   = tmr;
      cs_n_nxt  = cs_n;
      dclk_nxt  = dclk;
      din_nxt   = din;
      x_cap_nxt = x_cap;
      x_nxt     = x_coord;
      y_nxt     = y_coord;
      new_nxt   = 1'b0;
      samp_nxt  = 1'b0;
      half_inc  = half_cnt + 6'd1;
      cmd       = (state == XFER_Y) ? CMD_Y : CMD_X;

      case (state)
         IDLE: begin
            cs_n_nxt = 1'b1;
            dclk_nxt = 1'b0;
            din_nxt  = 1'b0;
            if (!pen_s) begin
               state_nxt = XFER_X;
               cs_n_nxt  = 1'b0;
               din_nxt   = CMD_X[7];
               div_nxt   = '0;
               half_nxt  = '0;
            end
         end

         // Half-period h (0..47): DCLK = h[0]. Rising edge n sits at h = 2n-1.
         // DIN bit 7-h/2 is launched at the start of each low half (h even).
         XFER_X, XFER_Y: begin
            if (div_cnt == DIV_LAST) begin
               div_nxt = '0;
               if (half_cnt == HALF_LAST) begin
                  // 24th falling edge coincides with CS_N rising
                  cs_n_nxt = 1'b1;
                  dclk_nxt = 1'b0;
                  din_nxt  = 1'b0;
                  tmr_nxt  = '0;
                  if (state == XFER_X) begin
                     state_nxt = GAP;
                     x_cap_nxt = shreg;
                  end else begin
                     state_nxt = DONE;
                  end
               end else begin
                  half_nxt = half_inc;
                  dclk_nxt = half_inc[0];
                  if (!half_inc[0])
                     din_nxt = (half_inc < 6'd16) ? cmd[3'd7 - half_inc[3:1]] : 1'b0;
                  // data bits D11..D0 arrive on rising edges 10..21
                  samp_nxt = half_inc[0] && (half_inc >= 6'd19) && (half_inc <= 6'd41);
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end

         GAP: begin
            if (tmr == GAP_LAST) begin
               state_nxt = XFER_Y;
               cs_n_nxt  = 1'b0;
               din_nxt   = CMD_Y[7];
               div_nxt   = '0;
               half_nxt  = '0;
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end

         DONE: begin
            x_nxt     = x_cap;
            y_nxt     = shreg;
            new_nxt   = 1'b1;
            tmr_nxt   = '0;
            state_nxt = HOLDOFF;
         end

         HOLDOFF: begin
            if (tmr == HOLD_LAST) state_nxt = IDLE;
            else tmr_nxt = tmr + TMR_W'(1);
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign ADC_CS_N  = cs_n;
   assign ADC_DCLK  = dclk;
   assign ADC_DIN   = din;
   assign X_COORD   = x_coord;
   assign Y_COORD   = y_coord;
   assign NEW_COORD = new_coord;

endmodule

// File: tb/tb_touch_adc_reader.sv
// Testbench for touch_adc_reader: ADC pin model plus a behavioural
// expectation of frame timing, command bits and published coordinates.
module tb_touch_adc_reader;
   localparam int CD   = 2;
   localparam int HO   = 10;
   localparam int PAIR = 98 * CD + 1;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        PEN = 1'b1;
   logic        DOUT = 1'b0;
   logic        cs_n, dclk, din, new_c;
   logic [11:0] xc, yc;

   touch_adc_reader #(.CLK_DIV(CD), .HOLDOFF_CYC(HO), .CMD_X(8'h92), .CMD_Y(8'hD2)) dut (
      .CLK(CLK), .RST(RST), .ADC_PENIRQ_N(PEN), .ADC_DOUT(DOUT),
      .ADC_CS_N(cs_n), .ADC_DCLK(dclk), .ADC_DIN(din),
      .X_COORD(xc), .Y_COORD(yc), .NEW_COORD(new_c));

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rst_edge = 1'b0;

   always @(posedge CLK) begin
      cyc      <= cyc + 1;
      rst_edge <= RST;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // What the ADC drives for rising edge n of a frame returning d:
   // data on 10..21, inverted neighbours on the busy bit and trailing edges.
   function automatic logic bit_for(input int n, input logic [11:0] d);
      if (n >= 10 && n <= 21) return d[21 - n];
      if (n == 9)             return ~d[11];
      if (n >= 22)            return ~d[0];
      return 1'($urandom);
   endfunction

   // model state
   bit          in_frame = 0, fip = 0, pend = 0;
   int          fall_cyc = 0, x_start = 0, end_cyc = 0, pub_cyc = 0;
   int          rise_n = 0, frames = 0, h = 0;
   logic [11:0] ex = '0, ey = '0, px = '0, py = '0, cur_x = '0, cur_y = '0, cur_d = '0;
   logic [7:0]  cmd_rx = '0, cmd_e = '0;
   logic        dclk_prev = 1'b0, exp_dclk, exp_din, exp_new;
   logic [11:0] vq[$];

   always @(negedge CLK) begin
      if (cyc >= 1) begin
         if (rst_edge) begin
            in_frame = 0; fip = 0; pend = 0; rise_n = 0;
            ex = '0; ey = '0; dclk_prev = 1'b0;
            chk("reset_outputs", {cs_n, dclk, din, new_c, xc, yc}, {1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
         end else begin
            if (in_frame && (cs_n || (cyc - fall_cyc) >= 48 * CD)) begin
               chk("cs_low_len", {cs_n, 32'(cyc - fall_cyc)}, {1'b1, 32'(48 * CD)});
               in_frame = 0;
               end_cyc  = cyc;
               if (fip) begin
                  pend = 1; pub_cyc = x_start + PAIR; px = cur_x; py = cur_y; fip = 0;
               end else begin
                  fip = 1;
               end
            end else if (!in_frame && !cs_n) begin
               in_frame = 1; fall_cyc = cyc; rise_n = 0; frames++;
               if (fip) chk("gap_len", 32'(cyc - end_cyc), 32'(2 * CD));
               else x_start = cyc;
               DOUT = bit_for(1, 12'h000);
            end

            exp_dclk = 1'b0;
            exp_din  = 1'b0;
            if (in_frame) begin
               h = (cyc - fall_cyc) / CD;
               exp_dclk = h[0];
               cmd_e = fip ? 8'hD2 : 8'h92;
               if (h < 16) exp_din = cmd_e[7 - h / 2];
               if (dclk && !dclk_prev) begin
                  rise_n++;
                  if (rise_n <= 8) cmd_rx = {cmd_rx[6:0], din};
                  if (rise_n == 8) begin
                     chk("cmd_byte", cmd_rx, cmd_e);
                     cur_d = (vq.size() > 0) ? vq.pop_front() : 12'($urandom);
                     if (fip) cur_y = cur_d;
                     else     cur_x = cur_d;
                  end
               end else if (!dclk && dclk_prev) begin
                  DOUT = bit_for(rise_n + 1, cur_d);
               end
            end

            exp_new = pend && (cyc == pub_cyc);
            if (exp_new) begin
               ex = px; ey = py; pend = 0;
            end
            chk("outputs", {dclk, din, new_c, xc, yc}, {exp_dclk, exp_din, exp_new, ex, ey});
            dclk_prev = dclk;
         end
      end
   end

   task automatic wait_pulse(input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge CLK);
         if (new_c === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL pulse_timeout: no NEW_COORD within %0d cycles", max);
      end
   endtask

   task automatic pen(input logic v);
      @(posedge CLK);
      #1 PEN = v;
   endtask

   initial begin
      int p, t1, t2, t3, f0;

      // reset and idle
      RST = 1'b1; PEN = 1'b1; DOUT = 1'b0;
      repeat (5) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_x", xc, 12'h000);
      f0 = frames;
      repeat (40) @(posedge CLK);
      chk("idle_no_frames", frames, f0);

      // single pair with latency checks
      vq.push_back(12'hA5C); vq.push_back(12'h3F1);
      @(posedge CLK);
      #1 PEN = 1'b0;
      p = cyc;
      for (int i = 0; i < 20 && frames == f0; i++) @(negedge CLK);
      chk("pen_latency", 32'(x_start - p), 32'd3);
      pen(1'b1);
      wait_pulse(400, t1);
      chk("pair_latency", 32'(t1 - x_start), 32'd197);
      chk("x_single", xc, 12'hA5C);
      chk("y_single", yc, 12'h3F1);
      repeat (30) @(posedge CLK);
      f0 = frames;
      repeat (60) @(posedge CLK);
      chk("idle_after_single", frames, f0);

      // boundary data
      vq.push_back(12'h000); vq.push_back(12'hFFF);
      vq.push_back(12'hFFF); vq.push_back(12'h001);
      pen(1'b0);
      wait_pulse(400, t1);
      chk("x_bound0", xc, 12'h000);
      chk("y_bound0", yc, 12'hFFF);
      wait_pulse(400, t2);
      pen(1'b1);
      chk("x_bound1", xc, 12'hFFF);
      chk("y_bound1", yc, 12'h001);
      chk("bound_spacing", 32'(t2 - t1), 32'd208);
      repeat (40) @(posedge CLK);

      // pen held: three random pairs
      pen(1'b0);
      wait_pulse(400, t1);
      wait_pulse(400, t2);
      wait_pulse(400, t3);
      pen(1'b1);
      chk("held_spacing1", 32'(t2 - t1), 32'd208);
      chk("held_spacing2", 32'(t3 - t2), 32'd208);
      repeat (40) @(posedge CLK);

      // pen lift during XFER_Y
      pen(1'b0);
      for (int i = 0; i < 400 && !(fip && in_frame); i++) @(posedge CLK);
      #1 PEN = 1'b1;
      wait_pulse(400, t1);
      chk("lift_x", xc, px);
      f0 = frames;
      repeat (100) @(posedge CLK);
      chk("lift_idle", frames, f0);

      // reset at DCLK rising edge 15 of XFER_X
      pen(1'b0);
      for (int i = 0; i < 400 && !(in_frame && !fip && rise_n == 15); i++) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("midrst_cs_dclk", {cs_n, dclk, new_c}, 3'b100);
      chk("midrst_xy", {xc, yc}, 24'h000000);
      vq.push_back(12'h5A3); vq.push_back(12'h0C7);
      wait_pulse(400, t1);
      pen(1'b1);
      chk("midrst_latency", 32'(t1 - x_start), 32'd197);
      chk("x_fresh", xc, 12'h5A3);
      chk("y_fresh", yc, 12'h0C7);
      repeat (40) @(posedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/touch_adc_reader.md
# touch_adc_reader

Serial front end for the panel's touch ADC (ADS7843-style, SPI-like). It waits for pen-down, then reads one 12-bit X and one 12-bit Y conversion. It publishes both coordinates together with a one-cycle strobe, and repeats while the pen stays down. Its X_COORD/Y_COORD outputs drive the 7-segment coordinate display and any other coordinate consumer.

## Interface
Parameters:
- CLK_DIV, 25: CLK cycles per DCLK half-period (DCLK = CLK/(2·CLK_DIV), 1 MHz at 50 MHz); legal range ≥ 2.
- HOLDOFF_CYC, 500000: idle CLK cycles between end of one sample pair and next pen check (100 Hz at 50 MHz); legal range ≥ 1.
- CMD_X, 8'h92: control byte for X conversion.
- CMD_Y, 8'hD2: control byte for Y conversion.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- ADC_PENIRQ_N  in  1  pen-down, active low, asynchronous to CLK.
- ADC_DOUT  in  1  serial data from ADC.
- ADC_CS_N  out  1  chip select, active low.
- ADC_DCLK  out  1  serial clock.
- ADC_DIN  out  1  serial command to ADC.
- X_COORD  out  12  last X result.
- Y_COORD  out  12  last Y result.
- NEW_COORD  out  1  one-cycle strobe; X_COORD/Y_COORD updated this cycle.

## Operation
- ADC_PENIRQ_N and ADC_DOUT pass through 2-flop synchronizers before use.
- Reset values: ADC_CS_N=1, ADC_DCLK=0, ADC_DIN=0, X_COORD=0, Y_COORD=0, NEW_COORD=0, state IDLE.
- FSM states: IDLE, XFER_X, GAP, XFER_Y, DONE, HOLDOFF.
- IDLE: CS_N=1, DCLK=0, DIN=0. Leaves to XFER_X on the first cycle the synchronized pen signal is 0.
- XFER_X / XFER_Y each perform one frame with CS_N=0 for exactly 24 DCLK periods:
  - DIN changes only while DCLK is low. It presents the command byte MSB first so bit 7 is stable before DCLK rising edge 1 and bit 0 before rising edge 8. DIN=0 from the falling edge after rising edge 8 to frame end.
  - DOUT is sampled at DCLK rising edges 10..21 as D11..D0 (MSB first) into a 12-bit shift register. Edge 9 is the busy bit and is ignored; edges 22..24 are ignored.
- GAP: CS_N=1, DCLK=0 for 2·CLK_DIV cycles, then XFER_Y.
- DONE lasts one cycle:
  - X_COORD and Y_COORD load together from the captured values; NEW_COORD=1.
  - X_COORD is never updated alone.
- HOLDOFF: count HOLDOFF_CYC cycles, then IDLE. If the pen is still down, the next pair starts immediately.
- The pen signal is ignored from XFER_X entry through HOLDOFF. A pair, once started, always completes and publishes, even if the pen lifts mid-frame.
- Outputs hold their last values indefinitely while idle.
- RST asserted in any state, mid-frame included:
  - next cycle returns to reset values, with CS_N forced high and DCLK low;
  - the partial capture is discarded and NEW_COORD does not pulse.

## Timing
- Frame timing:
  - DCLK toggles every CLK_DIV cycles.
  - First rising edge occurs CLK_DIV cycles after CS_N falls.
  - CS_N rises in the same cycle as the 24th falling edge of DCLK.
  - Frame length is exactly 48·CLK_DIV cycles.
- DCLK has 50% duty cycle; no glitches; low whenever CS_N=1.
- Latency: 2 sync cycles + 1 IDLE cycle from ADC_PENIRQ_N falling to CS_N falling.
- CS_N fall of X to NEW_COORD is 98·CLK_DIV + 1 cycles (48 + 2 + 48 half-period groups, plus DONE).
- NEW_COORD is high exactly 1 cycle per pair. Pair-to-pair spacing with pen held is 98·CLK_DIV + 1 + HOLDOFF_CYC + 1 cycles.
- DIN setup to DCLK rise ≥ CLK_DIV cycles; DOUT sampled on the CLK edge where DCLK goes high (synchronizer delay is absorbed because the ADC updates DOUT on falling DCLK).
- Counter widths are sized from parameters; no wrap within a frame or holdoff.

## Test plan
- **Reset:** CLK_DIV=2, HOLDOFF_CYC=10; hold RST 5 cycles → all outputs at reset values; no DCLK activity with ADC_PENIRQ_N=1.
- **Single pair:** pen down; ADC model returns X=12'hA5C, Y=12'h3F1.
  - DIN carries 8'h92 then 8'hD2 on rising edges 1–8.
  - One NEW_COORD pulse with X_COORD=12'hA5C, Y_COORD=12'h3F1.
  - Each CS_N low window = 96 cycles; gap = 4 cycles.
- **Boundary data:** X=12'h000, Y=12'hFFF, then X=12'hFFF, Y=12'h001 → exact values; bits at edges 9 and 22–24 driven opposite to neighbouring data bits have no effect.
- **Pen held:** 3 consecutive pairs with distinct data → 3 NEW_COORD pulses spaced 98·2+1+10+1 = 208 cycles; outputs change only at pulses.
- **Pen lift mid-frame:** release pen during XFER_Y → the pair completes and publishes; the FSM then stays in IDLE with outputs held.
- **Reset mid-frame:** assert RST at DCLK edge 15 of XFER_X → next cycle CS_N=1, DCLK=0, X_COORD/Y_COORD=0, no NEW_COORD; after release with pen down, a fresh pair completes correctly.
